// File: rtl/serial_adder.sv
// Bit-serial adder: one full-adder cell reused over WIDTH cycles with a carry flop.
// Optional macro SERIAL_ADDER_OVF_EN adds a registered signed-overflow output ovf.
module serial_adder #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
`ifdef SERIAL_ADDER_OVF_EN
  output logic             co,
  output logic             ovf
`else
  output logic             co
`endif
);

  localparam int unsigned CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ADD  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state;
  logic [WIDTH-1:0] a_sr;
  logic [WIDTH-1:0] b_sr;
  logic [WIDTH-1:0] s_sr;
  logic             carry;
  logic [CNT_W-1:0] cnt;
  logic             s_bit_c;
  logic             c_next_c;

  // Single full-adder cell on the current LSBs
  always_comb begin
    s_bit_c  = a_sr[0] ^ b_sr[0] ^ carry;
    c_next_c = (a_sr[0] & b_sr[0]) | (a_sr[0] & carry) | (b_sr[0] & carry);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      busy  <= 1'b0;
      done  <= 1'b0;
      sum   <= '0;
      co    <= 1'b0;
`ifdef SERIAL_ADDER_OVF_EN
      ovf   <= 1'b0;
`endif
      a_sr  <= '0;
      b_sr  <= '0;
      s_sr  <= '0;
      carry <= 1'b0;
      cnt   <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            state <= ADD;
            busy  <= 1'b1;
            a_sr  <= a;
            b_sr  <= b;
            s_sr  <= '0;
            carry <= cin;
            cnt   <= '0;
          end
        end
        ADD: begin
          // Sum enters at the MSB so bit 0 lands at the LSB after WIDTH shifts
          a_sr  <= {1'b0, a_sr[WIDTH-1:1]};
          b_sr  <= {1'b0, b_sr[WIDTH-1:1]};
          s_sr  <= {s_bit_c, s_sr[WIDTH-1:1]};
          carry <= c_next_c;
          if (cnt == CNT_LAST) begin
            state <= DONE;
            done  <= 1'b1;
            sum   <= {s_bit_c, s_sr[WIDTH-1:1]};
            co    <= c_next_c;
`ifdef SERIAL_ADDER_OVF_EN
            ovf   <= carry ^ c_next_c;
`endif
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        DONE: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_serial_adder.sv
// Scoreboard bench for serial_adder: directed WIDTH=8 vectors and exhaustive WIDTH=4 sweep.
module tb_serial_adder;

  typedef struct packed {
    logic       ovf;
    logic       co;
    logic [7:0] sum;
  } exp8_t;

  typedef struct packed {
    logic       ovf;
    logic       co;
    logic [3:0] sum;
  } exp4_t;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       start8, cin8, busy8, done8, co8;
  logic [7:0] a8, b8, sum8;
  logic       start4, cin4, busy4, done4, co4;
  logic [3:0] a4, b4, sum4;
`ifdef SERIAL_ADDER_OVF_EN
  logic       ovf8, ovf4;
`endif

  int checks = 0;
  int errors = 0;
  exp8_t q8[$];
  exp4_t q4[$];

  always #5 clk = ~clk;

  serial_adder #(.WIDTH(8)) dut8 (
    .clk(clk), .rst_n(rst_n), .start(start8), .a(a8), .b(b8), .cin(cin8),
    .busy(busy8), .done(done8), .sum(sum8),
`ifdef SERIAL_ADDER_OVF_EN
    .co(co8), .ovf(ovf8)
`else
    .co(co8)
`endif
  );

  serial_adder #(.WIDTH(4)) dut4 (
    .clk(clk), .rst_n(rst_n), .start(start4), .a(a4), .b(b4), .cin(cin4),
    .busy(busy4), .done(done4), .sum(sum4),
`ifdef SERIAL_ADDER_OVF_EN
    .co(co4), .ovf(ovf4)
`else
    .co(co4)
`endif
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitors: pop the oldest expectation whenever a done pulse is presented
  always @(negedge clk) begin
    if (rst_n && done8) begin
      if (q8.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_done8: got done=1 expected no pending result at %0t", $time);
      end else begin
        exp8_t e;
        e = q8.pop_front();
        chk("sum8", 32'(sum8), 32'(e.sum));
        chk("co8", 32'(co8), 32'(e.co));
`ifdef SERIAL_ADDER_OVF_EN
        chk("ovf8", 32'(ovf8), 32'(e.ovf));
`endif
      end
    end
  end

  always @(negedge clk) begin
    if (rst_n && done4) begin
      if (q4.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_done4: got done=1 expected no pending result at %0t", $time);
      end else begin
        exp4_t e;
        e = q4.pop_front();
        chk("sum4", 32'(sum4), 32'(e.sum));
        chk("co4", 32'(co4), 32'(e.co));
`ifdef SERIAL_ADDER_OVF_EN
        chk("ovf4", 32'(ovf4), 32'(e.ovf));
`endif
      end
    end
  end

  task automatic wait_done8();
    for (int i = 0; i < 32 && !done8; i++) @(negedge clk);
    chk("done8_seen", 32'(done8), 32'd1);
  endtask

  task automatic run8(input logic [7:0] ta, input logic [7:0] tb_v, input logic tc,
                      input logic [7:0] es, input logic ec, input logic eo);
    exp8_t e;
    @(negedge clk);
    a8 = ta; b8 = tb_v; cin8 = tc; start8 = 1'b1;
    e.ovf = eo; e.co = ec; e.sum = es;
    q8.push_back(e);
    @(negedge clk);
    start8 = 1'b0; a8 = ~ta; b8 = ~tb_v; cin8 = ~tc;
    wait_done8();
    @(negedge clk);
  endtask

  task automatic run4(input logic [3:0] ta, input logic [3:0] tb_v, input logic tc);
    exp4_t e;
    logic [4:0] r;
    r = 5'(ta) + 5'(tb_v) + 5'(tc);
    e.sum = r[3:0];
    e.co  = r[4];
    e.ovf = (ta[3] == tb_v[3]) && (r[3] != ta[3]);
    @(negedge clk);
    a4 = ta; b4 = tb_v; cin4 = tc; start4 = 1'b1;
    q4.push_back(e);
    @(negedge clk);
    start4 = 1'b0; a4 = ~ta; b4 = ~tb_v; cin4 = ~tc;
    for (int i = 0; i < 16 && !done4; i++) @(negedge clk);
    chk("done4_seen", 32'(done4), 32'd1);
    @(negedge clk);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int busy_cnt;
    int done_at;
    int n;
    exp8_t e;
    rst_n = 1'b0;
    start8 = 1'b0; a8 = '0; b8 = '0; cin8 = 1'b0;
    start4 = 1'b0; a4 = '0; b4 = '0; cin4 = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_busy", 32'(busy8), 32'd0);
    chk("rst_done", 32'(done8), 32'd0);
    chk("rst_sum", 32'(sum8), 32'd0);
    chk("rst_co", 32'(co8), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // Latency and busy window on 0+0
    a8 = 8'h00; b8 = 8'h00; cin8 = 1'b0; start8 = 1'b1;
    e.ovf = 1'b0; e.co = 1'b0; e.sum = 8'h00;
    q8.push_back(e);
    @(negedge clk);
    start8 = 1'b0;
    busy_cnt = 0;
    done_at = -1;
    for (int i = 0; i < 20; i++) begin
      if (done8 && done_at < 0) done_at = i;
      if (!busy8) break;
      busy_cnt++;
      @(negedge clk);
    end
    chk("busy_cycles", 32'(busy_cnt), 32'd9);
    chk("done_latency", 32'(done_at), 32'd8);

    run8(8'hA5, 8'h5A, 1'b1, 8'h00, 1'b1, 1'b0);
    run8(8'h12, 8'h34, 1'b0, 8'h46, 1'b0, 1'b0);
    run8(8'h7F, 8'h01, 1'b0, 8'h80, 1'b0, 1'b1);
    run8(8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, 1'b0);
    run8(8'h12, 8'h34, 1'b0, 8'h46, 1'b0, 1'b0);

    // Start during ADD is ignored; outputs hold the previous result meanwhile
    @(negedge clk);
    a8 = 8'h01; b8 = 8'h01; cin8 = 1'b0; start8 = 1'b1;
    e.ovf = 1'b0; e.co = 1'b0; e.sum = 8'h02;
    q8.push_back(e);
    @(negedge clk);
    start8 = 1'b0;
    repeat (2) @(negedge clk);
    chk("hold_sum", 32'(sum8), 32'h46);
    chk("hold_co", 32'(co8), 32'd0);
    a8 = 8'hFF; b8 = 8'hFF; start8 = 1'b1;
    @(negedge clk);
    start8 = 1'b0;
    wait_done8();
    repeat (14) @(negedge clk);
    chk("ignored_busy", 32'(busy8), 32'd0);

    // Start held high: three back-to-back results
    @(negedge clk);
    a8 = 8'h01; b8 = 8'h02; cin8 = 1'b0; start8 = 1'b1;
    e.ovf = 1'b0; e.co = 1'b0; e.sum = 8'h03;
    repeat (3) q8.push_back(e);
    n = 0;
    for (int i = 0; i < 60 && n < 3; i++) begin
      @(negedge clk);
      if (done8) n++;
    end
    start8 = 1'b0;
    chk("b2b_count", 32'(n), 32'd3);
    repeat (3) @(negedge clk);

    // Reset mid-operation discards the partial result
    a8 = 8'hF0; b8 = 8'h0F; cin8 = 1'b1; start8 = 1'b1;
    @(negedge clk);
    start8 = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("midrst_busy", 32'(busy8), 32'd0);
    chk("midrst_done", 32'(done8), 32'd0);
    chk("midrst_sum", 32'(sum8), 32'd0);
    chk("midrst_co", 32'(co8), 32'd0);
`ifdef SERIAL_ADDER_OVF_EN
    chk("midrst_ovf", 32'(ovf8), 32'd0);
`endif
    @(negedge clk);
    rst_n = 1'b1;
    repeat (12) @(negedge clk);
    run8(8'hF0, 8'h0F, 1'b1, 8'h00, 1'b1, 1'b0);

    // Exhaustive WIDTH=4 sweep
    for (int i = 0; i < 16; i++)
      for (int j = 0; j < 16; j++)
        for (int c = 0; c < 2; c++)
          run4(4'(i), 4'(j), 1'(c));

    repeat (4) @(negedge clk);
    chk("q8_drained", 32'(q8.size()), 32'd0);
    chk("q4_drained", 32'(q4.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
